// File: rtl/pacote_memoria.sv
// Shared types and constants for the data-memory arbiter.
package pacote_memoria;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    localparam logic PORTA_CPU   = 1'b0;
    localparam logic PORTA_DEBUG = 1'b1;

    localparam int TAMANHO_BYTES_PADRAO = 256;

endpackage

// File: rtl/arbitro_memoria_dados_if.sv
// Requester-side bundle: one instance per port of the data-memory arbiter.
interface arbitro_memoria_dados_if #(
    parameter int LARGURA_DADO     = 16,
    parameter int LARGURA_ENDERECO = 16
);

    // req rises with a stable payload and stays high until the one-cycle ack;
    // dado_lido and erro are meaningful only while ack=1.
    logic                        req;
    logic                        escrita;
    logic [LARGURA_ENDERECO-1:0] endereco;
    logic [LARGURA_DADO-1:0]     dado_escrita;
    logic                        ack;
    logic [LARGURA_DADO-1:0]     dado_lido;
    logic                        erro;

    modport master (
        output req, escrita, endereco, dado_escrita,
        input  ack, dado_lido, erro
    );

    modport slave (
        input  req, escrita, endereco, dado_escrita,
        output ack, dado_lido, erro
    );

endinterface

// File: rtl/arbitro_round_robin_2.sv
// Two-way round-robin grant: a tie goes to the port that was not served last.
module arbitro_round_robin_2
    import pacote_memoria::*;
(
    input  logic [1:0] req,
    input  logic       ultimo_concedido,
    input  logic       atualiza,
    output logic       concedido,
    output logic       valido
);

    always_comb begin
        concedido = PORTA_CPU;
        if (req == 2'b11) begin
            concedido = ~ultimo_concedido;
        end else if (req[1]) begin
            concedido = PORTA_DEBUG;
        end
        valido = atualiza && (req != 2'b00);
    end

endmodule

// File: rtl/arbitro_memoria_dados.sv
// Shares one single-port data memory between the CPU and debug ports,
// one access at a time, with address legality checked at grant.
module arbitro_memoria_dados
    import pacote_memoria::*;
#(
    parameter int LARGURA_DADO     = 16,
    parameter int LARGURA_ENDERECO = 16,
    parameter int TAMANHO_BYTES    = TAMANHO_BYTES_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset_n,
    arbitro_memoria_dados_if.slave      p0,
    arbitro_memoria_dados_if.slave      p1,
    output logic                        mem_permisao_escrita,
    output logic                        mem_permisao_leitura,
    output logic [LARGURA_ENDERECO-1:0] mem_endereco,
    output logic [LARGURA_DADO-1:0]     mem_dado_escrita,
    input  logic [LARGURA_DADO-1:0]     mem_dado_leitura,
    output logic                        ocupado,
    output estado_t                     estado_depuracao
);

    localparam logic [LARGURA_ENDERECO-1:0] ENDERECO_MAXIMO =
        LARGURA_ENDERECO'(TAMANHO_BYTES - 2);

    estado_t                     estado, proximo;
    logic                        ultimo_concedido;
    logic                        porta_reg;
    logic                        escrita_reg;
    logic                        erro_reg;
    logic [LARGURA_ENDERECO-1:0] endereco_reg;
    logic [LARGURA_DADO-1:0]     dado_escrita_reg;
    logic [LARGURA_DADO-1:0]     dado_reg;

    logic                        concedido;
    logic                        concessao_valida;
    logic                        escrita_sel;
    logic [LARGURA_ENDERECO-1:0] endereco_sel;
    logic [LARGURA_DADO-1:0]     dado_sel;
    logic                        legal;
    logic [LARGURA_DADO-1:0]     dado_resposta;

    arbitro_round_robin_2 u_round_robin (
        .req              ({p1.req, p0.req}),
        .ultimo_concedido (ultimo_concedido),
        .atualiza         (estado == OCIOSO),
        .concedido        (concedido),
        .valido           (concessao_valida)
    );

    always_comb begin
        escrita_sel  = (concedido == PORTA_DEBUG) ? p1.escrita      : p0.escrita;
        endereco_sel = (concedido == PORTA_DEBUG) ? p1.endereco     : p0.endereco;
        dado_sel     = (concedido == PORTA_DEBUG) ? p1.dado_escrita : p0.dado_escrita;
        legal        = !endereco_sel[0] && (endereco_sel <= ENDERECO_MAXIMO);
    end

    always_comb begin
        proximo              = estado;
        mem_permisao_escrita = 1'b0;
        mem_permisao_leitura = 1'b0;
        p0.ack               = 1'b0;
        p1.ack               = 1'b0;
        p0.erro              = 1'b0;
        p1.erro              = 1'b0;
        p0.dado_lido         = '0;
        p1.dado_lido         = '0;
        // Writes and rejected requests never return memory data.
        dado_resposta        = (erro_reg || escrita_reg) ? '0 : dado_reg;
        unique case (estado)
            OCIOSO: begin
                if (concessao_valida) begin
                    proximo = legal ? ACESSO : RESPOSTA;
                end
            end
            ACESSO: begin
                mem_permisao_escrita = escrita_reg;
                mem_permisao_leitura = !escrita_reg;
                proximo              = RESPOSTA;
            end
            RESPOSTA: begin
                if (porta_reg == PORTA_DEBUG) begin
                    p1.ack       = 1'b1;
                    p1.erro      = erro_reg;
                    p1.dado_lido = dado_resposta;
                end else begin
                    p0.ack       = 1'b1;
                    p0.erro      = erro_reg;
                    p0.dado_lido = dado_resposta;
                end
                proximo = OCIOSO;
            end
            default: proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado           <= OCIOSO;
            ultimo_concedido <= PORTA_DEBUG;
            porta_reg        <= PORTA_CPU;
            escrita_reg      <= 1'b0;
            erro_reg         <= 1'b0;
            endereco_reg     <= '0;
            dado_escrita_reg <= '0;
            dado_reg         <= '0;
        end else begin
            estado <= proximo;
            if (concessao_valida) begin
                ultimo_concedido <= concedido;
                porta_reg        <= concedido;
                escrita_reg      <= escrita_sel;
                erro_reg         <= !legal;
                endereco_reg     <= endereco_sel;
                dado_escrita_reg <= dado_sel;
            end
            if (estado == ACESSO && !escrita_reg) begin
                dado_reg <= mem_dado_leitura;
            end
        end
    end

    assign mem_endereco     = endereco_reg;
    assign mem_dado_escrita = dado_escrita_reg;
    assign ocupado          = (estado != OCIOSO);
    assign estado_depuracao = estado;

endmodule

// File: doc/arbitro_memoria_dados.md
Name: arbitro_memoria_dados

Overview:
Sequences and shares the single-port 16-bit byte-addressed data memory between two requesters: port 0 (CPU MEM stage) and port 1 (debug/loader). Each requester uses a req/ack handshake. The block latches one request, drives the memory control and address lines for exactly one access cycle, and returns registered read data with an ack pulse. It also rejects misaligned and out-of-range addresses before they reach the memory.

Parameters:
LARGURA_DADO, 16, data word width (bits)
LARGURA_ENDERECO, 16, byte address width
TAMANHO_BYTES, 256, memory capacity in bytes; highest legal word address is TAMANHO_BYTES-2

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
p0_req / p1_req  in  1  request valid; held with its payload until ack
p0_escrita / p1_escrita  in  1  1=write, 0=read
p0_endereco / p1_endereco  in  LARGURA_ENDERECO  byte address
p0_dado_escrita / p1_dado_escrita  in  LARGURA_DADO  write data
p0_ack / p1_ack  out  1  one-cycle completion pulse
p0_dado_lido / p1_dado_lido  out  LARGURA_DADO  read data, valid while ack=1
p0_erro / p1_erro  out  1  valid while ack=1; request rejected
mem_permisao_escrita  out  1  to memory write enable
mem_permisao_leitura  out  1  to memory read enable
mem_endereco  out  LARGURA_ENDERECO  to memory address
mem_dado_escrita  out  LARGURA_DADO  to memory write data
mem_dado_leitura  in  LARGURA_DADO  from memory (combinational read)
ocupado  out  1  high whenever state is not OCIOSO

Behaviour:
- Reset (async, reset_n=0): state=OCIOSO; all acks, erros, dado_lido, mem_* outputs and ocupado=0; ultimo_concedido=1, so port 0 wins the first tie.
- FSM states: OCIOSO -> ACESSO -> RESPOSTA -> OCIOSO. An error path goes OCIOSO -> RESPOSTA directly.
- OCIOSO: at each rising edge, sample p0_req/p1_req.
  - If neither is set, stay in OCIOSO.
  - If one is set, grant it.
  - If both are set, grant the port opposite ultimo_concedido (round-robin). Then set ultimo_concedido to the granted port.
  - On grant, latch escrita, endereco and dado_escrita of the granted port.
- Legality check at grant: the address is legal iff endereco[0]=0 and endereco <= TAMANHO_BYTES-2.
  - Legal: go to ACESSO.
  - Illegal: go to RESPOSTA with erro_reg=1. No memory enable is ever asserted for that request.
- ACESSO (exactly 1 cycle):
  - mem_endereco and mem_dado_escrita carry the latched values.
  - mem_permisao_escrita = latched escrita; mem_permisao_leitura = not latched escrita.
  - The memory performs the write at the closing edge.
  - For a read, mem_dado_leitura is captured into the data register at the closing edge.
- RESPOSTA (exactly 1 cycle):
  - Granted port's ack=1.
  - dado_lido = captured data for a read; 0 for a write or an error.
  - erro = erro_reg. The other port's ack stays 0.
- Enables are decoded from registered state only (no combinational path from req). mem_endereco and mem_dado_escrita hold their last latched value outside ACESSO.
- Latency: req sampled at edge k -> ACESSO during cycle k+1 -> ack during cycle k+2. Error path: ack during cycle k+1.
- Requester rule: drop req (or present a new request) in the cycle after ack is seen. A req still high at the end of the OCIOSO cycle is a new request.
- A losing requester keeps req high and is granted on the next OCIOSO. Round-robin bounds its wait to one access.
- Changing payload while req=1 before ack: undefined; the bench asserts this never happens.
- A req falling before grant is simply not served. A req falling after grant does not cancel the access.
- reset_n asserted during ACESSO: the write enable drops immediately (async). Whether the memory write happens is undefined; no ack is issued.

Decomposition:
- Shared package (pacote_memoria):
  - state encoding OCIOSO=2'd0, ACESSO=2'd1, RESPOSTA=2'd2
  - port index constants PORTA_CPU=0, PORTA_DEBUG=1
  - default TAMANHO_BYTES
- One sub-module: arbitro_round_robin_2. Inputs: 2 requests, the ultimo_concedido register, and an update strobe. Output: grant index and a valid flag.
- The FSM, latches and legality check stay in the top module.

Test Plan:
- Port 0 write 16'hBEEF at 0x0010, then port 0 read 0x0010. Required: write ack at cycle k+2 with erro=0; read ack carries dado_lido=16'hBEEF; mem_permisao_escrita high for exactly 1 cycle.
- Both ports request from reset: p0 read 0x0000, p1 read 0x0002, both held. Required: p0 served first; p1 ack 3 cycles later; no cycle has both acks high.
- Both ports request continuously for 6 accesses. Required: grant order 0,1,0,1,0,1.
- p1 read at 0x0011 (misaligned) and at 0x00FF (out of range). Required: ack at cycle k+1 with erro=1 and dado_lido=0; mem enables never asserted.
- p1 write 16'h1234 to 0x00FE, read back. Required: 16'h1234; the top-legal-address boundary is accepted.
- reset_n pulled low during ACESSO of a p0 write. Required: all outputs 0 immediately; ocupado=0; no ack; next p0 request after reset completes normally.
